// File: rtl/psa_pkg.sv
// Shared definitions for the parallel-signed-adder datapath.
// Used by psa_operand_collector (serial-to-parallel front end) and by the
// downstream parallel_signed_adder.
//   PSA_W     : operand width (two's complement)
//   PSA_N     : operands per frame
//   PSA_SUM_W : width of the adder's full-precision sum
//   sample_t  : one signed operand
//   state_t   : collector state (FILL = collecting, FULL = frame presented)
package psa_pkg;

  localparam int PSA_W     = 12;
  localparam int PSA_N     = 8;
  localparam int PSA_SUM_W = 15;

  typedef logic signed [PSA_W-1:0] sample_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/psa_operand_collector.sv
// psa_operand_collector
// Collects a stream of signed samples (valid/ready) into frames of eight and
// presents each frame as parallel operands n0..n7 until the consumer takes it.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : sample handshake (in_ready depends only on state
//                         and out_ready)
//   in_data             : sample, passed through unmodified
//   in_first            : marks in_data as slot 0 of a new frame (resync)
//   out_valid/out_ready : frame handshake
//   n0..n7              : frame operands, n0 = first sample
//   frame_err           : sticky, set when a partial frame is discarded
//   frames_done         : count of consumed frames, wraps modulo 256
module psa_operand_collector
  import psa_pkg::*;
#(
  parameter int W = PSA_W,
  parameter int N = PSA_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] n0,
  output logic [W-1:0] n1,
  output logic [W-1:0] n2,
  output logic [W-1:0] n3,
  output logic [W-1:0] n4,
  output logic [W-1:0] n5,
  output logic [W-1:0] n6,
  output logic [W-1:0] n7,
  output logic         frame_err,
  output logic [7:0]   frames_done
);

  localparam int CW = $clog2(N);

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic [W-1:0]  slot [N];

  logic          accept;
  logic          wr_en;
  logic [CW-1:0] wr_idx;
  logic          err_set;
  logic          done_inc;

  // While FULL, a ready consumer frees the slots on the same edge, so a
  // sample can be taken in the handoff cycle without a bubble.
  assign in_ready = (state == FILL) | out_ready;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    wr_en      = 1'b0;
    wr_idx     = '0;
    err_set    = 1'b0;
    done_inc   = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (in_first) begin
            // Resync: restart the frame at slot 0; anything collected so
            // far is dropped and flagged.
            wr_idx     = '0;
            count_next = CW'(1);
            err_set    = (count != '0);
          end else begin
            wr_idx = count;
            if (count == CW'(N - 1)) begin
              count_next = '0;
              state_next = FULL;
            end else begin
              count_next = count + CW'(1);
            end
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          done_inc   = 1'b1;
          state_next = FILL;
          // Handoff sample always starts the next frame; in_first is moot.
          if (accept) begin
            wr_en      = 1'b1;
            wr_idx     = '0;
            count_next = CW'(1);
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) slot[i] <= '0;
      frame_err   <= 1'b0;
      frames_done <= '0;
    end else begin
      if (wr_en) slot[wr_idx] <= in_data;
      if (err_set) frame_err <= 1'b1;
      if (done_inc) frames_done <= frames_done + 8'd1;
    end
  end

  // out_valid is a direct decode of the state register.
  assign out_valid = (state == FULL);

  assign n0 = slot[0];
  assign n1 = slot[1];
  assign n2 = slot[2];
  assign n3 = slot[3];
  assign n4 = slot[4];
  assign n5 = slot[5];
  assign n6 = slot[6];
  assign n7 = slot[7];

endmodule
